// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and timing limits used by both TX and RX.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int MIN_PRESCALE       = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Edge counter and bit index for the transmitter; bit_done pulses in the last cycle of each bit.
module uart_tx_baud_cnt #(
    parameter int PRESCALE_WIDTH = 8,
    parameter int IDX_W          = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      run,
    input  logic                      bit_adv,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done,
    output logic [IDX_W-1:0]          bit_idx
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    assign bit_done = run && (cnt_q == prescale - PRESCALE_WIDTH'(1));
    assign bit_idx  = idx_q;

    // The counter clears on every bit boundary, so each bit lasts exactly prescale cycles.
    always_comb begin
        cnt_d = '0;
        idx_d = idx_q;
        if (clear) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (run) begin
            cnt_d = bit_done ? '0 : cnt_q + PRESCALE_WIDTH'(1);
            if (bit_done && bit_adv) begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/uart_tx_up.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// Handshake: DATA_VALID is taken only in the cycle busy=0; requests seen while busy=1 are dropped.
module uart_tx_up
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic [2:0]                state_dbg
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_MIN = PRESCALE_WIDTH'(MIN_PRESCALE);

    logic [2:0]                state_q, state_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic                      par_en_q, par_en_d;
    logic                      par_bit_q, par_bit_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic                      accept;
    logic                      bit_done;
    logic [IDX_W-1:0]          bit_idx;
    logic [PRESCALE_WIDTH-1:0] presc_clamped;

    assign presc_clamped = (prescale < PRESC_MIN) ? PRESC_MIN : prescale;
    assign accept        = (state_q == ST_IDLE) && DATA_VALID;

    uart_tx_baud_cnt #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH),
        .IDX_W         (IDX_W)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .run     (state_q != ST_IDLE),
        .bit_adv (state_q == ST_DATA),
        .prescale(presc_q),
        .bit_done(bit_done),
        .bit_idx (bit_idx)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        presc_d   = presc_q;
        case (state_q)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    state_d   = ST_START;
                    shift_d   = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ PAR_TYP;
                    presc_d   = presc_clamped;
                end
            end
            ST_START:  if (bit_done) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx == LAST_IDX) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: if (bit_done) state_d = ST_STOP;
            ST_STOP:   if (bit_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Line level is decoded from the next state so TX_OUT stays a plain register.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_q;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= PRESC_MIN;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            presc_q   <= presc_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT    = tx_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_up.sv
// Directed bench for uart_tx_up: frames are compared cycle by cycle against hand-built bit patterns.
module tb_uart_tx_up;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] prescale = 8'd8;
    logic       TX_OUT;
    logic       busy;
    logic [2:0] state_dbg;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_up #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .prescale  (prescale),
        .TX_OUT    (TX_OUT),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_state(input int b, input int nbits);
        if (b == 0)                        return ST_START;
        else if (b == nbits - 1)           return ST_STOP;
        else if (b == 9 && nbits == 11)    return ST_PARITY;
        else                               return ST_DATA;
    endfunction

    // Called at the first negedge after the acceptance edge; walks every cycle of the frame.
    task automatic check_bits(input string tag, input int p, input int nbits,
                              input logic [10:0] exp_bits, input bit pulse_dv);
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < p; k++) begin
                chk($sformatf("%s tx b%0d c%0d", tag, b, k), 8'(TX_OUT), 8'(exp_bits[b]));
                chk($sformatf("%s busy b%0d c%0d", tag, b, k), 8'(busy), 8'd1);
                if (k == 0)
                    chk($sformatf("%s state b%0d", tag, b), 8'(state_dbg), 8'(exp_state(b, nbits)));
                if (pulse_dv) DATA_VALID = (b == 2 && k == 1);
                @(negedge clk);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle tx"}, 8'(TX_OUT), 8'd1);
        chk({tag, " idle busy"}, 8'(busy), 8'd0);
        chk({tag, " idle state"}, 8'(state_dbg), 8'(ST_IDLE));
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] data, input logic pe,
                                  input logic pt, input logic [7:0] presc, input int p,
                                  input int nbits, input logic [10:0] exp_bits);
        P_DATA = data; PAR_EN = pe; PAR_TYP = pt; prescale = presc; DATA_VALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Scramble every input once the frame is captured.
        DATA_VALID = 1'b0; P_DATA = ~data; PAR_EN = ~pe; PAR_TYP = ~pt; prescale = presc ^ 8'h0F;
        check_bits(tag, p, nbits, exp_bits, 1'b1);
        check_idle(tag);
        @(negedge clk);
        check_idle({tag, " +1"});
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("after reset");

        // 0xA5 even parity (4 ones -> 0), prescale 8, 11 bits
        send_and_check("a5_even", 8'hA5, 1'b1, 1'b0, 8'd8, 8, 11, {1'b1, 1'b0, 8'hA5, 1'b0});
        // 0xA5 odd parity -> 1
        send_and_check("a5_odd", 8'hA5, 1'b1, 1'b1, 8'd8, 8, 11, {1'b1, 1'b1, 8'hA5, 1'b0});
        // 0x07 even parity (3 ones -> 1)
        send_and_check("07_even", 8'h07, 1'b1, 1'b0, 8'd8, 8, 11, {1'b1, 1'b1, 8'h07, 1'b0});
        // No parity, 0xFF, prescale 16 -> 160-cycle frame
        send_and_check("ff_nopar", 8'hFF, 1'b0, 1'b0, 8'd16, 16, 10, {1'b0, 1'b1, 8'hFF, 1'b0});
        // prescale 2 clamps to 4; 0x5A has 4 ones -> even parity 0
        send_and_check("clamp2", 8'h5A, 1'b1, 1'b0, 8'd2, 4, 11, {1'b1, 1'b0, 8'h5A, 1'b0});
        // prescale 4 is the smallest legal value and is used as-is
        send_and_check("p4", 8'h81, 1'b0, 1'b0, 8'd4, 4, 10, {1'b0, 1'b1, 8'h81, 1'b0});

        // Back-to-back: DATA_VALID held high across two frames
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 8'd4; DATA_VALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        P_DATA = 8'hC3;
        check_bits("b2b_1", 4, 10, {1'b0, 1'b1, 8'h3C, 1'b0}, 1'b0);
        check_idle("b2b gap");
        @(negedge clk);
        DATA_VALID = 1'b0;
        check_bits("b2b_2", 4, 10, {1'b0, 1'b1, 8'hC3, 1'b0}, 1'b0);
        check_idle("b2b end");

        // Reset in the 4th data bit (time slot 4), with DATA_VALID also high
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; prescale = 8'd8; DATA_VALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        DATA_VALID = 1'b0;
        repeat (4 * 8 + 3) @(negedge clk);
        chk("pre-reset busy", 8'(busy), 8'd1);
        chk("pre-reset state", 8'(state_dbg), 8'(ST_DATA));
        rst = 1'b1;
        DATA_VALID = 1'b1;
        #1;
        chk("async rst tx", 8'(TX_OUT), 8'd1);
        chk("async rst busy", 8'(busy), 8'd0);
        @(posedge clk);
        @(negedge clk);
        check_idle("rst+dv");
        rst = 1'b0;
        DATA_VALID = 1'b0;
        @(negedge clk);
        check_idle("post reset");
        send_and_check("clean", 8'h96, 1'b1, 1'b1, 8'd8, 8, 11, {1'b1, 1'b1, 8'h96, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
